seg7_capture: RTL and testbench

Recovers the two-digit hexadecimal value shown on a pair of 7-segment outputs. It is the decode-side counterpart of the lab05b display drivers. It watches `display1`/`display2` each clock and waits until the pattern pair has been stable for a programmable number of cycles. It then reports the decoded byte with a one-cycle `valid` pulse and flags blank or illegal digits. It sits beside the lab05b display path for self-checking benches and for on-board readback logic.

---
 rtl/seg7_pkg.sv | 31 +++
 rtl/seg7_digit_decode.sv | 11 +
 rtl/seg7_capture.sv | 59 +++++
 tb/tb_seg7_capture.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: active-low 7-segment code constants, capture FSM states and the digit decode function.
package seg7_pkg;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_CODES [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                            SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
  typedef enum logic {SETTLE, REPORT} state_t;
  // Returns {ok, blank, nibble}; anything unrecognised yields nibble 0 with ok and blank both low.
  function automatic logic [5:0] seg_decode(input logic [6:0] code);
    logic [5:0] r;
    r = {1'b0, code == SEG_BLANK, 4'h0};
    for (int i = 0; i < 16; i++)
      if (code == SEG_CODES[i]) r = {2'b10, 4'(i)};
    return r;
  endfunction
endpackage

// File: rtl/seg7_digit_decode.sv
// seg7_digit_decode: combinational decode of one active-low 7-segment digit.
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [6:0] code,
  output logic       ok,
  output logic       blank,
  output logic [3:0] nibble
);
  assign {ok, blank, nibble} = seg_decode(code);
endmodule

// File: rtl/seg7_capture.sv
// seg7_capture: reports the byte on a pair of 7-segment displays once it has been stable long enough.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       clean,
  input  logic [6:0] display1,
  input  logic [6:0] display2,
  output logic [7:0] value,
  output logic       valid,
  output logic       blank_hi,
  output logic       blank_lo,
  output logic       err,
  output logic [7:0] capture_cnt
);
  localparam logic [3:0] sc = 4'(STABLE_CYCLES);
  localparam logic [13:0] dark = {SEG_BLANK, SEG_BLANK};
  state_t state, state_nx;
  logic [13:0] pair, samp, rep;
  logic [3:0] cnt, nib_h, nib_l;
  logic ok_h, ok_l, bl_h, bl_l;
  assign pair = {display1, display2};
  assign valid = state == REPORT;
  seg7_digit_decode u_hi (.code(samp[13:7]), .ok(ok_h), .blank(bl_h), .nibble(nib_h));
  seg7_digit_decode u_lo (.code(samp[6:0]), .ok(ok_l), .blank(bl_l), .nibble(nib_l));
  always_comb state_nx = (state == SETTLE && cnt == sc && samp != rep) ? REPORT : SETTLE;
  always_ff @(posedge clk)
    state <= clean ? SETTLE : state_nx;
  // Reset treats the dark display as already reported, so it never pulses.
  always_ff @(posedge clk) begin
    if (clean) begin
      samp <= dark;
      rep <= dark;
      cnt <= sc;
      value <= 8'h00;
      blank_hi <= 1'b1;
      blank_lo <= 1'b1;
      err <= 1'b0;
      capture_cnt <= 8'h00;
    end else begin
      if (pair != samp) begin
        samp <= pair;
        cnt <= 4'd1;
      end else if (cnt < sc) begin
        cnt <= cnt + 4'd1;
      end
      if (state_nx == REPORT) begin
        rep <= samp;
        value <= {nib_h, nib_l};
        blank_hi <= bl_h;
        blank_lo <= bl_l;
        err <= (!ok_h && !bl_h) || (!ok_l && !bl_l);
        capture_cnt <= capture_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: table-driven, hand-written and randomized checks of seg7_capture against a run-length model.
module tb_seg7_capture;
  localparam int S = 4;
  logic clk = 1'b0;
  logic clean = 1'b1;
  logic [6:0] display1 = 7'h7F, display2 = 7'h7F;
  logic [7:0] value, capture_cnt;
  logic valid, blank_hi, blank_lo, err;
  always #5 clk = ~clk;
  seg7_capture #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .clean(clean), .display1(display1), .display2(display2),
    .value(value), .valid(valid), .blank_hi(blank_hi), .blank_lo(blank_lo),
    .err(err), .capture_cnt(capture_cnt)
  );
  int n_checks = 0, n_fail = 0, pulses = 0;
  logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  // Model: the current pair and how many consecutive edges it has been seen (unbounded).
  logic [13:0] m_samp, m_rep;
  int m_run;
  logic m_valid, m_bh, m_bl, m_err;
  logic [7:0] m_value, m_cap;
  typedef struct {
    logic [6:0] d1, d2;
    int hold, pulses;
    logic [7:0] value;
    logic bh, bl, er;
    logic [7:0] cap;
  } vec_t;
  vec_t tbl [8];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  task automatic ref_digit(input logic [6:0] c, output logic [3:0] nib, output logic blank, output logic bad);
    nib = 4'h0;
    blank = c == 7'h7F;
    bad = !blank;
    for (int i = 0; i < 16; i++)
      if (codes[i] == c) begin
        nib = 4'(i);
        bad = 1'b0;
      end
  endtask
  task automatic model_edge(input logic r, input logic [13:0] p);
    logic [3:0] nh, nl;
    logic bh, bl, eh, el;
    if (r) begin
      m_samp = 14'h3FFF;
      m_rep = 14'h3FFF;
      m_run = 1000;
      m_valid = 0;
      m_value = 0;
      m_bh = 1;
      m_bl = 1;
      m_err = 0;
      m_cap = 0;
    end else begin
      m_valid = m_run >= S && m_samp != m_rep;
      if (m_valid) begin
        ref_digit(m_samp[13:7], nh, bh, eh);
        ref_digit(m_samp[6:0], nl, bl, el);
        m_value = {nh, nl};
        m_bh = bh;
        m_bl = bl;
        m_err = eh | el;
        m_rep = m_samp;
        m_cap = m_cap + 8'd1;
      end
      if (p == m_samp) m_run++;
      else begin
        m_samp = p;
        m_run = 1;
      end
    end
  endtask
  task automatic step(input logic [6:0] a, input logic [6:0] b, input logic r);
    display1 = a;
    display2 = b;
    clean = r;
    @(posedge clk);
    model_edge(r, {a, b});
    #1;
    if (valid) pulses++;
    check("cycle", {12'h0, valid, value, blank_hi, blank_lo, err, capture_cnt},
          {12'h0, m_valid, m_value, m_bh, m_bl, m_err, m_cap});
  endtask
  initial begin
    int first;
    logic [6:0] a, b;
    tbl[0] = '{7'h7F, 7'h7F, 10, 0, 8'h00, 1, 1, 0, 8'd0};
    tbl[1] = '{7'h19, 7'h12, 6, 1, 8'h45, 0, 0, 0, 8'd1};
    tbl[2] = '{7'h06, 7'h0E, 2, 0, 8'h45, 0, 0, 0, 8'd1};
    tbl[3] = '{7'h19, 7'h12, 6, 0, 8'h45, 0, 0, 0, 8'd1};
    tbl[4] = '{7'h7E, 7'h40, 6, 1, 8'h00, 0, 0, 1, 8'd2};
    tbl[5] = '{7'h7F, 7'h40, 6, 1, 8'h00, 1, 0, 0, 8'd3};
    tbl[6] = '{7'h03, 7'h21, 6, 1, 8'hBD, 0, 0, 0, 8'd4};
    tbl[7] = '{7'h7F, 7'h7F, 6, 1, 8'h00, 1, 1, 0, 8'd5};
    for (int i = 0; i < 3; i++) step(7'h7F, 7'h7F, 1);
    check("reset_outputs", {valid, value, blank_hi, blank_lo, err, capture_cnt}, {1'b0, 8'h00, 3'b110, 8'h00});
    for (int t = 0; t < 8; t++) begin
      pulses = 0;
      for (int i = 0; i < tbl[t].hold; i++) step(tbl[t].d1, tbl[t].d2, 0);
      check($sformatf("tbl%0d_pulses", t), pulses, tbl[t].pulses);
      check($sformatf("tbl%0d_value", t), value, tbl[t].value);
      check($sformatf("tbl%0d_flags", t), {blank_hi, blank_lo, err}, {tbl[t].bh, tbl[t].bl, tbl[t].er});
      check($sformatf("tbl%0d_cap", t), capture_cnt, tbl[t].cap);
    end
    first = -1;
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      step(7'h40, 7'h79, 0);
      if (valid && first < 0) first = i;
    end
    check("latency_edge", first, S + 1);
    check("latency_pulses", pulses, 1);
    check("latency_value", value, 8'h01);
    step(7'h30, 7'h24, 0);
    step(7'h30, 7'h24, 0);
    step(7'h30, 7'h24, 1);
    check("reset_mid_valid", valid, 1'b0);
    check("reset_mid_cap", capture_cnt, 8'd0);
    first = -1;
    for (int i = 1; i <= 8; i++) begin
      step(7'h30, 7'h24, 0);
      if (valid && first < 0) first = i;
    end
    check("post_reset_edge", first, S + 1);
    check("post_reset_value", value, 8'h32);
    step(7'h7F, 7'h7F, 1);
    pulses = 0;
    for (int k = 0; k < 256; k++)
      for (int i = 0; i < 5; i++)
        if (k % 2 == 0) step(7'h40, 7'h40, 0);
        else step(7'h79, 7'h79, 0);
    check("wrap_pulses", pulses, 256);
    check("wrap_cap", capture_cnt, 8'd0);
    check("wrap_value", value, 8'h11);
    a = 7'h7F;
    b = 7'h7F;
    for (int seg = 0; seg < 300; seg++) begin
      int r, hold;
      logic rst;
      r = $urandom_range(0, 19);
      if (r < 16) begin
        a = codes[r];
        b = codes[$urandom_range(0, 15)];
      end else if (r == 16) a = 7'h7F;
      else if (r == 17) b = 7'h7E;
      else if (r == 18) begin
        a = 7'($urandom);
        b = 7'($urandom);
      end
      hold = $urandom_range(1, 7);
      rst = $urandom_range(0, 39) == 0;
      for (int i = 0; i < hold; i++) step(a, b, rst && i == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
